dino_game_engine_multi: RTL and testbench
=========================================

// Module: dino_game_engine_multi
// PURPOSE
//  Next-generation Chrome-dino game engine: runs once per game frame (game_clk ~60 Hz).
//  Handles jump physics, N_OBS independent obstacle lanes, per-lane hitbox collision,
//  speed ramp, day/night toggle, animation and a saturating score.
//  Feeds the renderer (dino_y, obstacle_x bus, dino_state, night) and the score display.
// PARAMETERS
//  W            12   coordinate width; y grows downward, obstacle_x is signed
//  N_OBS        2    number of obstacle lanes (1..8)
//  GROUND_Y     300  dino foot y when standing
//  DINO_X       60   fixed dino x (foot/centre column)
//  JUMP_V       10   initial upward velocity at take-off
//  GRAVITY      1    velocity decrement per frame
//  OBS_INIT_X   400  respawn x for any lane
//  OBS_SPACING  200  start offset between lanes: lane i starts at OBS_INIT_X + i*OBS_SPACING
//  SPEED_INIT   3    obstacle speed (px/frame) after start
//  SPEED_STEP   2    speed increment per ramp period
//  SPEED_MAX    20   speed saturation value
//  RAMP_FRAMES  600  RUN frames per ramp period (>=2)
//  HIT_HALF_W   10   obstacle hitbox half-width about obstacle_x
//  HIT_H        40   obstacle height above ground
//  ANIM_DIV     4    RUN frames per run-animation toggle
// PORTS
//  game_clk    in   1        frame clock, all logic on rising edge
//  reset       in   1        asynchronous, active-high
//  jump        in   1        jump request, sampled each frame
//  start       in   1        start/restart request
//  night       out  1        night-mode flag
//  dino_y      out  W        dino foot y
//  obstacle_x  out  N_OBS*W  lane i at [i*W +: W], signed
//  game_over   out  1        1 while in OVER
//  dino_state  out  2        0 RUN1, 1 RUN2, 2 JUMP, 3 COLLIDED
//  score       out  16       RUN frames survived, saturates at 16'hFFFF
// BEHAVIOUR
//  - One clock, game_clk; reset is asynchronous and active-high. On reset: state IDLE,
//    dino_y=GROUND_Y, velocity=0, obstacle_x[i]=OBS_INIT_X+i*OBS_SPACING, speed=SPEED_INIT,
//    game_over=0, night=0, dino_state=0, score=0, frame/anim counters=0. Reset mid-RUN aborts at once.
//  - FSM IDLE -> RUN on start=1; OVER -> RUN on start=1; RUN -> OVER on collision. start in RUN ignored.
//  - Entering RUN (same edge as start seen): re-apply all reset values except state=RUN; no motion that frame.
//  - In IDLE/OVER all outputs hold; jump ignored.
//  - RUN frame order, all from registered values at frame start:
//    1. Collision if any lane i: |obstacle_x[i]-DINO_X| <= HIT_HALF_W (signed, W+1 bit) AND
//       dino_y > GROUND_Y-HIT_H. Then: state=OVER, game_over=1, dino_state=3; positions, speed,
//       score, night frozen (no step 2-5 this frame).
//    2. Physics (signed velocity v, upward positive): if jump && v==0 && dino_y==GROUND_Y:
//       v=JUMP_V, dino_state=2, y unchanged. Else if dino_y - v >= GROUND_Y (signed): dino_y=GROUND_Y,
//       v=0, dino_state={1'b0,anim}. Else dino_y=dino_y-v, v=v-GRAVITY (dino_state stays 2 while airborne).
//    3. Each lane: if obstacle_x[i] <= 0 then obstacle_x[i]=OBS_INIT_X else obstacle_x[i]-=speed.
//       Lane may go negative by up to speed-1 for one frame; respawn next frame. Lanes independent.
//    4. anim toggles every ANIM_DIV RUN frames; ground dino_state follows on the next landing/run frame.
//    5. score+1 saturating. frame counter counts 0..RAMP_FRAMES-1; on wrap speed=min(speed+SPEED_STEP,
//       SPEED_MAX) and night toggles (simultaneous with that frame's motion, new speed used next frame).
//  - Collision and jump same frame: collision wins. Collision and respawn same frame: collision wins.
// TESTING
//  1. Reset pulse mid-RUN (async, between edges) -> all outputs to reset values immediately, state IDLE.
//  2. start, then jump 1 frame -> y: 300,290,281,...,246,245,245,246,...,290,300; apex 245;
//     lands 21 frames after take-off with v=0, dino_state in {0,1}; second jump accepted next frame.
//  3. Hold jump high continuously -> re-jumps only on frames where y==300 && v==0; never mid-air.
//  4. N_OBS=2, no jump: lane0 hits DINO_X±10 with y=300 -> game_over=1, dino_state=3, outputs frozen;
//     start -> RUN with lane0=400, lane1=600, score=0.
//  5. RAMP_FRAMES=4: speed 3,5,7,... saturates at 20 after 9 periods; night toggles every 4 RUN frames;
//     lane at x=2, speed 3 -> -1 then 400.
//  6. Force score to 16'hFFFE -> 16'hFFFF and holds; start while RUN ignored (no reinit).

Source files
------------

// File: rtl/dino_game_engine_multi.sv
// Chrome-dino frame engine: jump physics, N_OBS obstacle lanes with hitbox collision,
// speed ramp, day/night toggle, run animation and saturating score; one step per game_clk.
module dino_game_engine_multi #(
  parameter int W           = 12,
  parameter int N_OBS       = 2,
  parameter int GROUND_Y    = 300,
  parameter int DINO_X      = 60,
  parameter int JUMP_V      = 10,
  parameter int GRAVITY     = 1,
  parameter int OBS_INIT_X  = 400,
  parameter int OBS_SPACING = 200,
  parameter int SPEED_INIT  = 3,
  parameter int SPEED_STEP  = 2,
  parameter int SPEED_MAX   = 20,
  parameter int RAMP_FRAMES = 600,
  parameter int HIT_HALF_W  = 10,
  parameter int HIT_H       = 40,
  parameter int ANIM_DIV    = 4
) (
  input  logic               game_clk,
  input  logic               reset,
  input  logic               jump,
  input  logic               start,
  output logic               night,
  output logic [W-1:0]       dino_y,
  output logic [N_OBS*W-1:0] obstacle_x,
  output logic               game_over,
  output logic [1:0]         dino_state,
  output logic [15:0]        score
);
  localparam int unsigned FRAME_W = $clog2(RAMP_FRAMES);
  localparam int unsigned ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_t;
  state_t state_q, state_d;

  logic [W-1:0]        y_q, y_d;
  logic signed [W-1:0] vel_q, vel_d;
  logic signed [W-1:0] obs_q [N_OBS];
  logic signed [W-1:0] obs_d [N_OBS];
  logic [W-1:0]        speed_q, speed_d;
  logic                night_q, night_d, go_q, go_d, anim_q, anim_d;
  logic [1:0]          ds_q, ds_d;
  logic [15:0]         score_q, score_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [ANIM_W-1:0]   anim_cnt_q, anim_cnt_d;

  logic                hit_c;
  logic signed [W:0]   diff_c [N_OBS];
  logic signed [W:0]   y_fall_c;
  logic [W:0]          speed_sum_c;

  assign y_fall_c    = $signed({1'b0, y_q}) - $signed({vel_q[W-1], vel_q});
  assign speed_sum_c = {1'b0, speed_q} + (W+1)'(SPEED_STEP);

  // Any lane inside the dino's column while the dino is low enough to touch it
  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      diff_c[i] = $signed({obs_q[i][W-1], obs_q[i]}) - $signed((W+1)'(DINO_X));
      if ((diff_c[i] <= $signed((W+1)'(HIT_HALF_W))) &&
          (diff_c[i] >= -$signed((W+1)'(HIT_HALF_W))))
        hit_c = 1'b1;
    end
    hit_c = hit_c && ({1'b0, y_q} > (W+1)'(GROUND_Y - HIT_H));
  end

  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_RUN;
      S_RUN:          if (hit_c) state_d = S_OVER;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    y_d        = y_q;
    vel_d      = vel_q;
    obs_d      = obs_q;
    speed_d    = speed_q;
    night_d    = night_q;
    go_d       = go_q;
    anim_d     = anim_q;
    ds_d       = ds_q;
    score_d    = score_q;
    frame_d    = frame_q;
    anim_cnt_d = anim_cnt_q;
    if (state_q != S_RUN) begin
      // (Re)start: fresh game, no motion on the start frame
      if (start) begin
        y_d        = W'(GROUND_Y);
        vel_d      = '0;
        for (int i = 0; i < N_OBS; i++) obs_d[i] = W'(OBS_INIT_X + i*OBS_SPACING);
        speed_d    = W'(SPEED_INIT);
        night_d    = 1'b0;
        go_d       = 1'b0;
        anim_d     = 1'b0;
        ds_d       = 2'd0;
        score_d    = '0;
        frame_d    = '0;
        anim_cnt_d = '0;
      end
    end else if (hit_c) begin
      go_d = 1'b1;
      ds_d = 2'd3;
    end else begin
      if (jump && vel_q == '0 && y_q == W'(GROUND_Y)) begin
        vel_d = $signed(W'(JUMP_V));
        ds_d  = 2'd2;
      end else if (y_fall_c >= $signed((W+1)'(GROUND_Y))) begin
        y_d   = W'(GROUND_Y);
        vel_d = '0;
        ds_d  = {1'b0, anim_q};
      end else begin
        y_d   = y_fall_c[W-1:0];
        vel_d = vel_q - $signed(W'(GRAVITY));
        ds_d  = 2'd2;
      end
      for (int i = 0; i < N_OBS; i++) begin
        if (obs_q[i][W-1] || obs_q[i] == '0) obs_d[i] = W'(OBS_INIT_X);
        else                                 obs_d[i] = obs_q[i] - $signed(speed_q);
      end
      if (anim_cnt_q == ANIM_W'(ANIM_DIV - 1)) begin
        anim_cnt_d = '0;
        anim_d     = ~anim_q;
      end else begin
        anim_cnt_d = anim_cnt_q + ANIM_W'(1);
      end
      score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
      // Ramp wrap: faster obstacles from the next frame, flip day/night
      if (frame_q == FRAME_W'(RAMP_FRAMES - 1)) begin
        frame_d = '0;
        speed_d = (speed_sum_c > (W+1)'(SPEED_MAX)) ? W'(SPEED_MAX) : speed_sum_c[W-1:0];
        night_d = ~night_q;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      y_q        <= W'(GROUND_Y);
      vel_q      <= '0;
      for (int i = 0; i < N_OBS; i++) obs_q[i] <= W'(OBS_INIT_X + i*OBS_SPACING);
      speed_q    <= W'(SPEED_INIT);
      night_q    <= 1'b0;
      go_q       <= 1'b0;
      anim_q     <= 1'b0;
      ds_q       <= 2'd0;
      score_q    <= '0;
      frame_q    <= '0;
      anim_cnt_q <= '0;
    end else begin
      y_q        <= y_d;
      vel_q      <= vel_d;
      obs_q      <= obs_d;
      speed_q    <= speed_d;
      night_q    <= night_d;
      go_q       <= go_d;
      anim_q     <= anim_d;
      ds_q       <= ds_d;
      score_q    <= score_d;
      frame_q    <= frame_d;
      anim_cnt_q <= anim_cnt_d;
    end
  end

  assign dino_y     = y_q;
  assign night      = night_q;
  assign game_over  = go_q;
  assign dino_state = ds_q;
  assign score      = score_q;

  for (genvar g = 0; g < N_OBS; g++) begin : g_lane
    assign obstacle_x[g*W +: W] = obs_q[g];
  end

endmodule

// File: tb/tb_dino_game_engine_multi.sv
// Bench for dino_game_engine_multi: a reference frame model predicts every frame into a
// queue; each scenario task pops and compares, plus targeted checks on jump, collision, ramp, score.
module tb_dino_game_engine_multi;
  logic        game_clk = 1'b0;
  logic        reset, jump, start, jump_r, start_r;
  logic        night, game_over, night_r, game_over_r;
  logic [11:0] dino_y, dino_y_r;
  logic [23:0] obstacle_x, obstacle_x_r;
  logic [1:0]  dino_state, dino_state_r;
  logic [15:0] score, score_r;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int y; int v; int obs0; int obs1; int speed; int ds;
    int score; int frame; int acnt; int st;
    bit night; bit go; bit anim;
  } mstate_t;

  mstate_t ms, mr;
  mstate_t exp_q[$];
  mstate_t rexp_q[$];

  dino_game_engine_multi dut (
    .game_clk(game_clk), .reset(reset), .jump(jump), .start(start),
    .night(night), .dino_y(dino_y), .obstacle_x(obstacle_x),
    .game_over(game_over), .dino_state(dino_state), .score(score));

  dino_game_engine_multi #(.RAMP_FRAMES(4), .HIT_H(0)) dut_r (
    .game_clk(game_clk), .reset(reset), .jump(jump_r), .start(start_r),
    .night(night_r), .dino_y(dino_y_r), .obstacle_x(obstacle_x_r),
    .game_over(game_over_r), .dino_state(dino_state_r), .score(score_r));

  always #5 game_clk = ~game_clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1);
  end

  function automatic mstate_t init_state();
    mstate_t s;
    s.y = 300; s.v = 0; s.obs0 = 400; s.obs1 = 600; s.speed = 3; s.ds = 0;
    s.score = 0; s.frame = 0; s.acnt = 0; s.st = 0;
    s.night = 0; s.go = 0; s.anim = 0;
    return s;
  endfunction

  // Reference frame model: st 0 idle, 1 run, 2 over
  function automatic mstate_t mnext(mstate_t s, logic j, logic strt, int ramp, int hit_h);
    mstate_t n;
    int d0, d1;
    n = s;
    if (s.st != 1) begin
      if (strt) begin
        n = init_state();
        n.st = 1;
      end
      return n;
    end
    d0 = s.obs0 - 60; if (d0 < 0) d0 = -d0;
    d1 = s.obs1 - 60; if (d1 < 0) d1 = -d1;
    if ((d0 <= 10 || d1 <= 10) && s.y > 300 - hit_h) begin
      n.st = 2; n.go = 1; n.ds = 3;
      return n;
    end
    if (j && s.v == 0 && s.y == 300) begin
      n.v = 10; n.ds = 2;
    end else if (s.y - s.v >= 300) begin
      n.y = 300; n.v = 0; n.ds = s.anim ? 1 : 0;
    end else begin
      n.y = s.y - s.v; n.v = s.v - 1; n.ds = 2;
    end
    n.obs0 = (s.obs0 <= 0) ? 400 : s.obs0 - s.speed;
    n.obs1 = (s.obs1 <= 0) ? 400 : s.obs1 - s.speed;
    if (s.acnt == 3) begin n.acnt = 0; n.anim = !s.anim; end
    else n.acnt = s.acnt + 1;
    n.score = (s.score < 65535) ? s.score + 1 : 65535;
    if (s.frame == ramp - 1) begin
      n.frame = 0;
      n.speed = (s.speed + 2 > 20) ? 20 : s.speed + 2;
      n.night = !s.night;
    end else n.frame = s.frame + 1;
    return n;
  endfunction

  function automatic logic [55:0] pack_exp(mstate_t e);
    return {e.night, 12'(e.y), 12'(e.obs1), 12'(e.obs0), e.go, 2'(e.ds), 16'(e.score)};
  endfunction

  function automatic logic [55:0] got_main();
    return {night, dino_y, obstacle_x, game_over, dino_state, score};
  endfunction

  function automatic logic [55:0] got_ramp();
    return {night_r, dino_y_r, obstacle_x_r, game_over_r, dino_state_r, score_r};
  endfunction

  task automatic step(input logic j, input logic s);
    @(negedge game_clk);
    jump = j; start = s;
    ms = mnext(ms, j, s, 600, 40);
    exp_q.push_back(ms);
    @(posedge game_clk); #1;
  endtask

  task automatic step_r(input logic j, input logic s);
    @(negedge game_clk);
    jump_r = j; start_r = s;
    mr = mnext(mr, j, s, 4, 0);
    rexp_q.push_back(mr);
    @(posedge game_clk); #1;
  endtask

  task automatic restart();
    @(negedge game_clk);
    reset = 1'b1; jump = 0; start = 0; jump_r = 0; start_r = 0;
    ms = init_state(); mr = init_state();
    exp_q.delete(); rexp_q.delete();
    @(negedge game_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mstate_t e;
    reset = 1'b1; jump = 0; start = 0; jump_r = 0; start_r = 0;
    ms = init_state(); mr = init_state();
    repeat (2) @(posedge game_clk);
    #1;
    e = init_state();
    checks++;
    if (got_main() !== pack_exp(e)) begin
      errors++; $display("FAIL reset_main: got %h expected %h", got_main(), pack_exp(e));
    end
    checks++;
    if (got_ramp() !== pack_exp(e)) begin
      errors++; $display("FAIL reset_ramp: got %h expected %h", got_ramp(), pack_exp(e));
    end
    @(negedge game_clk); reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      step(f == 1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got_main() !== pack_exp(e)) begin
        errors++; $display("FAIL idle_hold%0d: got %h expected %h", f, got_main(), pack_exp(e));
      end
    end
  endtask

  task automatic test_jump();
    mstate_t e;
    int apex, land_at;
    restart();
    step(0, 1); e = exp_q.pop_front();
    checks++;
    if (got_main() !== pack_exp(e)) begin
      errors++; $display("FAIL jump_start: got %h expected %h", got_main(), pack_exp(e));
    end
    step(1, 0); e = exp_q.pop_front();
    checks++;
    if (got_main() !== pack_exp(e) || dino_y !== 12'd300 || dino_state !== 2'd2) begin
      errors++; $display("FAIL takeoff: got y=%0d ds=%0d expected y=300 ds=2", dino_y, dino_state);
    end
    apex = 300; land_at = 0;
    for (int f = 1; f <= 25 && land_at == 0; f++) begin
      step(0, 0); e = exp_q.pop_front();
      checks++;
      if (got_main() !== pack_exp(e)) begin
        errors++; $display("FAIL jump_f%0d: got %h expected %h", f, got_main(), pack_exp(e));
      end
      if (int'(dino_y) < apex) apex = int'(dino_y);
      if (dino_y == 12'd300) land_at = f;
    end
    checks++;
    if (apex != 245) begin errors++; $display("FAIL apex: got %0d expected 245", apex); end
    checks++;
    if (land_at != 21) begin errors++; $display("FAIL land_frame: got %0d expected 21", land_at); end
    checks++;
    if (dino_state > 2'd1) begin
      errors++; $display("FAIL landed_state: got %0d expected 0 or 1", dino_state);
    end
    step(1, 0); e = exp_q.pop_front();
    checks++;
    if (got_main() !== pack_exp(e) || dino_state !== 2'd2) begin
      errors++; $display("FAIL rejump: got ds=%0d expected 2", dino_state);
    end
  endtask

  task automatic test_hold_jump();
    mstate_t e;
    int prev_y, prev_ds, takeoffs;
    restart();
    step(0, 1); e = exp_q.pop_front();
    prev_y = 300; prev_ds = 0; takeoffs = 0;
    for (int f = 1; f <= 50; f++) begin
      step(1, 0); e = exp_q.pop_front();
      checks++;
      if (got_main() !== pack_exp(e)) begin
        errors++; $display("FAIL hold_f%0d: got %h expected %h", f, got_main(), pack_exp(e));
      end
      if (dino_state == 2'd2 && dino_y == 12'd300) begin
        takeoffs++;
        checks++;
        if (prev_y != 300 || prev_ds == 2) begin
          errors++; $display("FAIL hold_takeoff_f%0d: got prev y=%0d ds=%0d expected y=300 grounded", f, prev_y, prev_ds);
        end
      end
      prev_y = int'(dino_y); prev_ds = int'(dino_state);
    end
    checks++;
    if (takeoffs != 3) begin errors++; $display("FAIL hold_takeoffs: got %0d expected 3", takeoffs); end
  endtask

  task automatic test_collision();
    mstate_t e;
    int hit_at;
    restart();
    step(0, 1); e = exp_q.pop_front();
    hit_at = 0;
    for (int f = 1; f <= 200 && hit_at == 0; f++) begin
      step(0, 0); e = exp_q.pop_front();
      checks++;
      if (got_main() !== pack_exp(e)) begin
        errors++; $display("FAIL run_f%0d: got %h expected %h", f, got_main(), pack_exp(e));
      end
      if (game_over === 1'b1) hit_at = f;
    end
    checks++;
    if (hit_at != 111) begin errors++; $display("FAIL collision_frame: got %0d expected 111", hit_at); end
    checks++;
    if (dino_state !== 2'd3 || obstacle_x !== {12'd270, 12'd70} || score !== 16'd110) begin
      errors++; $display("FAIL collision_outputs: got ds=%0d lanes=%h score=%0d expected 3 10e046 110",
                         dino_state, obstacle_x, score);
    end
    for (int f = 0; f < 3; f++) begin
      step(1, 0); e = exp_q.pop_front();
      checks++;
      if (got_main() !== pack_exp(e) || score !== 16'd110) begin
        errors++; $display("FAIL over_frozen%0d: got %h expected %h", f, got_main(), pack_exp(e));
      end
    end
    step(0, 1); e = exp_q.pop_front();
    checks++;
    if (got_main() !== pack_exp(e) || obstacle_x !== {12'd600, 12'd400} || score !== 16'd0 ||
        game_over !== 1'b0) begin
      errors++; $display("FAIL restart: got %h expected %h", got_main(), pack_exp(e));
    end
  endtask

  task automatic test_async_reset();
    mstate_t e;
    restart();
    step(0, 1); e = exp_q.pop_front();
    for (int f = 0; f < 10; f++) begin
      step(f == 2, 0); e = exp_q.pop_front();
      checks++;
      if (got_main() !== pack_exp(e)) begin
        errors++; $display("FAIL pre_reset_f%0d: got %h expected %h", f, got_main(), pack_exp(e));
      end
    end
    #1 reset = 1'b1;
    #1;
    e = init_state();
    checks++;
    if (got_main() !== pack_exp(e)) begin
      errors++; $display("FAIL async_reset: got %h expected %h", got_main(), pack_exp(e));
    end
    ms = init_state();
    #1 reset = 1'b0;
    step(0, 0); e = exp_q.pop_front();
    checks++;
    if (got_main() !== pack_exp(e)) begin
      errors++; $display("FAIL after_reset_idle: got %h expected %h", got_main(), pack_exp(e));
    end
  endtask

  task automatic test_ramp();
    mstate_t e;
    int prev0, prev1, cur0, cur1, exp_spd, respawns;
    restart();
    step_r(0, 1); e = rexp_q.pop_front();
    prev0 = 400; prev1 = 600; respawns = 0;
    for (int f = 1; f <= 60; f++) begin
      step_r(0, 0); e = rexp_q.pop_front();
      checks++;
      if (got_ramp() !== pack_exp(e)) begin
        errors++; $display("FAIL ramp_f%0d: got %h expected %h", f, got_ramp(), pack_exp(e));
      end
      cur0 = int'($signed(obstacle_x_r[11:0]));
      cur1 = int'($signed(obstacle_x_r[23:12]));
      exp_spd = 3 + 2 * ((f - 1) / 4);
      if (exp_spd > 20) exp_spd = 20;
      if (prev1 > 0) begin
        checks++;
        if (prev1 - cur1 != exp_spd) begin
          errors++; $display("FAIL ramp_speed_f%0d: got %0d expected %0d", f, prev1 - cur1, exp_spd);
        end
      end
      if (prev0 <= 0) begin
        respawns++;
        checks++;
        if (cur0 != 400) begin errors++; $display("FAIL respawn_f%0d: got %0d expected 400", f, cur0); end
      end
      if (f == 4 || f == 8) begin
        checks++;
        if (night_r !== (f == 4)) begin
          errors++; $display("FAIL night_f%0d: got %0b expected %0b", f, night_r, f == 4);
        end
      end
      prev0 = cur0; prev1 = cur1;
    end
    checks++;
    if (respawns < 1) begin errors++; $display("FAIL respawn_seen: got %0d expected >=1", respawns); end
  endtask

  task automatic test_score_sat();
    mstate_t e;
    for (int n = 0; n < 70000 && mr.score < 65534; n++) begin
      step_r(0, 0); e = rexp_q.pop_front();
    end
    checks++;
    if (got_ramp() !== pack_exp(e) || score_r !== 16'hFFFE) begin
      errors++; $display("FAIL score_fffe: got %h expected %h", got_ramp(), pack_exp(e));
    end
    for (int f = 0; f < 3; f++) begin
      step_r(0, f == 1); e = rexp_q.pop_front();
      checks++;
      if (got_ramp() !== pack_exp(e) || score_r !== 16'hFFFF) begin
        errors++; $display("FAIL score_sat%0d: got %h expected %h", f, got_ramp(), pack_exp(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_hold_jump();
    test_collision();
    test_async_reset();
    test_ramp();
    test_score_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
